// File: rtl/gbvga_pkg.sv
// rtl/gbvga_pkg.sv - shared Game Boy LCD / VGA geometry constants and helpers
package gbvga_pkg;

   localparam int GB_H_PIX     = 160;
   localparam int GB_V_LINES   = 144;
   localparam int GB_DATA_W    = 2;
   localparam int DEF_FILT_LEN = 4;

   // Smallest r with 2**r >= value; used to size counters from geometry.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/gb_sig_filter.sv
// rtl/gb_sig_filter.sv - 2-FF synchroniser plus run-length glitch filter with edge events
module gb_sig_filter
   import gbvga_pkg::*;
#(
   parameter int FILT_LEN = DEF_FILT_LEN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic state,
   output logic rise,
   output logic fall
);

   logic                s1, s2;
   logic [FILT_LEN-2:0] hist;
   logic [FILT_LEN-1:0] win;
   logic                flip;

   // Events are combinational so the write stage can register them on the flip edge.
   always_comb begin
      win  = {hist, s2};
      flip = state ? (win == '0) : (win == '1);
      rise = flip & ~state;
      fall = flip & state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         hist  <= '0;
         state <= 1'b0;
      end else begin
         s1    <= din;
         s2    <= s1;
         hist  <= win[FILT_LEN-2:0];
         state <= state ^ flip;
      end
   end

endmodule

// File: rtl/gb_lcd_capture.sv
// rtl/gb_lcd_capture.sv - LCD pixel stream capture into a double-buffered framebuffer write port
module gb_lcd_capture
   import gbvga_pkg::*;
#(
   parameter int FILT_LEN   = DEF_FILT_LEN,
   parameter int DATA_W     = GB_DATA_W,
   parameter int H_PIX      = GB_H_PIX,
   parameter int V_LINES    = GB_V_LINES,
   parameter int PIX_AW     = 15,
   parameter int DATA_DLY   = 5,
   parameter bit INVERT     = 1'b1,
   parameter bit DOUBLE_BUF = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iclk,
   input  logic              ihsync,
   input  logic              ivsync,
   input  logic [DATA_W-1:0] idata,
   output logic [PIX_AW:0]   wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              rd_bank,
   output logic              frame_done,
   output logic              err_line,
   output logic              err_frame
);

   localparam int XW = clog2(H_PIX + 1) + 1;
   localparam int LW = clog2(V_LINES + 1);
   localparam logic [XW-1:0]     X_MAX  = '1;
   localparam logic [XW-1:0]     X_END  = XW'(H_PIX);
   localparam logic [LW-1:0]     L_END  = LW'(V_LINES);
   localparam logic [PIX_AW-1:0] H_STEP = PIX_AW'(H_PIX);

   logic c_state, c_rise, c_fall;
   logic h_state, h_rise, h_fall;
   logic v_state, v_rise, v_fall;
   logic sig_unused;

   gb_sig_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk(clk), .rst_n(rst_n), .din(iclk),
      .state(c_state), .rise(c_rise), .fall(c_fall)
   );
   gb_sig_filter #(.FILT_LEN(FILT_LEN)) u_hs_filt (
      .clk(clk), .rst_n(rst_n), .din(ihsync),
      .state(h_state), .rise(h_rise), .fall(h_fall)
   );
   gb_sig_filter #(.FILT_LEN(FILT_LEN)) u_vs_filt (
      .clk(clk), .rst_n(rst_n), .din(ivsync),
      .state(v_state), .rise(v_rise), .fall(v_fall)
   );

   assign sig_unused = &{1'b0, c_state, c_rise, v_state, v_fall};

   logic [DATA_W-1:0] d_s1, d_s2;
   logic [DATA_W-1:0] d_dly [DATA_DLY];
   logic [DATA_W-1:0] pix_val;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_s1 <= '0;
         d_s2 <= '0;
         for (int i = 0; i < DATA_DLY; i++) d_dly[i] <= '0;
      end else begin
         d_s1     <= idata;
         d_s2     <= d_s1;
         d_dly[0] <= d_s2;
         for (int i = 1; i < DATA_DLY; i++) d_dly[i] <= d_dly[i-1];
      end
   end

   assign pix_val = INVERT ? ~d_dly[DATA_DLY-1] : d_dly[DATA_DLY-1];

   logic [XW-1:0]     x;
   logic [LW-1:0]     line;
   logic [PIX_AW-1:0] base;
   logic              wr_bank, armed;
   logic              p_ev, x_nz, err_l;
   logic [LW-1:0]     line_inc, line_after_l;

   // hsync fall clocks the first pixel of a line; later pixels come on iclk falls.
   always_comb begin
      p_ev         = h_fall | (c_fall & ~h_state);
      x_nz         = (x != '0);
      err_l        = armed & x_nz & (x != X_END);
      line_inc     = (line == L_END) ? line : line + LW'(1);
      line_after_l = x_nz ? line_inc : line;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x          <= '0;
         line       <= '0;
         base       <= '0;
         wr_bank    <= 1'b0;
         armed      <= 1'b0;
         rd_bank    <= DOUBLE_BUF;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         err_line   <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         err_line   <= 1'b0;
         err_frame  <= 1'b0;
         if (v_rise) begin
            // A pending partial line is closed out before the frame is judged.
            err_line <= err_l;
            if (armed) begin
               if (line_after_l == L_END) begin
                  frame_done <= 1'b1;
                  if (DOUBLE_BUF) begin
                     rd_bank <= wr_bank;
                     wr_bank <= ~wr_bank;
                  end
               end else begin
                  err_frame <= 1'b1;
               end
            end
            line  <= '0;
            base  <= '0;
            x     <= '0;
            armed <= 1'b1;
         end else if (h_rise) begin
            if (x_nz) begin
               err_line <= err_l;
               line     <= line_inc;
               if (line != L_END) base <= base + H_STEP;
            end
            x <= '0;
         end else if (p_ev) begin
            if (armed && x < X_END && line < L_END) begin
               wr_en   <= 1'b1;
               wr_addr <= {wr_bank, base + PIX_AW'(x)};
               wr_data <= pix_val;
            end
            // Keep counting past H_PIX so overlong lines are still flagged.
            if (x != X_MAX) x <= x + XW'(1);
         end
      end
   end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb/tb_gb_lcd_capture.sv - directed self-checking bench for gb_lcd_capture (16x8 geometry)
module tb_gb_lcd_capture;

   localparam int H = 16;
   localparam int V = 8;

   logic       clk;
   logic       rst_n;
   logic       iclk, ihsync, ivsync;
   logic [1:0] idata;
   logic [8:0] wr_addr;
   logic [1:0] wr_data;
   logic       wr_en, rd_bank, frame_done, err_line, err_frame;

   int n_checks = 0;
   int n_errors = 0;
   int fd_cnt = 0;
   int el_cnt = 0;
   int ef_cnt = 0;
   logic [8:0] wq[$];
   logic [1:0] dq[$];

   gb_lcd_capture #(
      .FILT_LEN(4), .DATA_W(2), .H_PIX(H), .V_LINES(V), .PIX_AW(8),
      .DATA_DLY(5), .INVERT(1'b1), .DOUBLE_BUF(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .iclk(iclk), .ihsync(ihsync), .ivsync(ivsync),
      .idata(idata), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .rd_bank(rd_bank), .frame_done(frame_done), .err_line(err_line),
      .err_frame(err_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wq.push_back(wr_addr);
         dq.push_back(wr_data);
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (err_line === 1'b1) el_cnt++;
      if (err_frame === 1'b1) ef_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_a(input int i);
      return (i < wq.size()) ? 32'(wq[i]) : 32'hDEAD;
   endfunction

   function automatic logic [31:0] get_d(input int i);
      return (i < dq.size()) ? 32'(dq[i]) : 32'hDEAD;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pixel();
      iclk = 1'b0;
      wait_cyc(6);
      iclk = 1'b1;
      wait_cyc(6);
   endtask

   task automatic line(input int n);
      ihsync = 1'b0;
      wait_cyc(8);
      repeat (n - 1) pixel();
      ihsync = 1'b1;
      wait_cyc(8);
   endtask

   task automatic frame_end();
      ivsync = 1'b1;
      wait_cyc(8);
      ivsync = 1'b0;
      wait_cyc(8);
   endtask

   initial begin
      int nbad;
      int lat;
      rst_n = 1'b0; iclk = 1'b1; ihsync = 1'b1; ivsync = 1'b0; idata = 2'b01;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_rd_bank", rd_bank, 1);
      check("rst_frame_done", frame_done, 0);
      check("rst_err_line", err_line, 0);
      check("rst_err_frame", err_frame, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      wait_cyc(10);

      // unarmed line, then the arming vsync
      line(H);
      check("unarmed_writes", wq.size(), 0);
      check("unarmed_err_line", el_cnt, 0);
      frame_end();
      check("arm_frame_done", fd_cnt, 0);
      check("arm_err_frame", ef_cnt, 0);
      check("arm_rd_bank", rd_bank, 1);

      // clean frame into bank 0, data 01 stored inverted as 10
      for (int l = 0; l < V; l++) line(H);
      check("clean_rd_bank_before", rd_bank, 1);
      frame_end();
      check("clean_write_count", wq.size(), H * V);
      nbad = 0;
      for (int i = 0; i < wq.size(); i++)
         if (wq[i] !== 9'(i) || dq[i] !== 2'b10) nbad++;
      check("clean_addr_data_bad", nbad, 0);
      check("clean_frame_done", fd_cnt, 1);
      check("clean_err_frame", ef_cnt, 0);
      check("clean_err_line", el_cnt, 0);
      check("clean_rd_bank_after", rd_bank, 0);

      // second frame writes bank 1; glitch and latency on line 0
      wq.delete(); dq.delete();
      ihsync = 1'b0;
      wait_cyc(8);
      check("f2_first_addr", get_a(0), 9'h100);
      iclk = 1'b0;
      wait_cyc(2);
      iclk = 1'b1;
      wait_cyc(10);
      check("glitch_no_write", wq.size(), 1);
      iclk = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (wr_en === 1'b1 && lat == 0) lat = k;
      end
      check("latency_edges", lat, 6);
      check("latency_addr", get_a(1), 9'h101);
      check("latency_data", get_d(1), 2'b10);
      iclk = 1'b1;
      wait_cyc(6);
      repeat (H - 2) pixel();
      ihsync = 1'b1;
      wait_cyc(8);
      check("f2_l0_count", wq.size(), H);
      check("f2_l0_err_line", el_cnt, 0);

      // short line, then next line with data 00 -> 11
      line(H - 2);
      check("short_err_line", el_cnt, 1);
      idata = 2'b00;
      wait_cyc(8);
      wq.delete(); dq.delete();
      line(H);
      check("after_short_addr", get_a(0), 9'h120);
      check("after_short_data", get_d(0), 2'b11);
      check("after_short_count", wq.size(), H);
      idata = 2'b01;
      wait_cyc(8);

      // overlong line
      wq.delete(); dq.delete();
      line(H + 3);
      check("long_count", wq.size(), H);
      check("long_last_addr", get_a(H - 1), 9'h13F);
      check("long_err_line", el_cnt, 2);

      // frame of V-1 lines
      repeat (3) line(H);
      frame_end();
      check("short_frame_err", ef_cnt, 1);
      check("short_frame_done", fd_cnt, 1);
      check("short_frame_rd_bank", rd_bank, 0);
      wq.delete(); dq.delete();
      line(1);
      check("f3_first_addr", get_a(0), 9'h100);
      check("f3_err_line", el_cnt, 3);

      // reset mid-line
      line(H);
      ihsync = 1'b0;
      wait_cyc(8);
      repeat (3) pixel();
      rst_n = 1'b0;
      wait_cyc(2);
      @(negedge clk);
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_wr_addr", wr_addr, 0);
      check("mid_rst_wr_data", wr_data, 0);
      check("mid_rst_rd_bank", rd_bank, 1);
      check("mid_rst_pulses", {err_line, err_frame, frame_done}, 0);
      ihsync = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(10);
      wq.delete(); dq.delete();
      line(H);
      check("post_rst_no_write", wq.size(), 0);
      check("post_rst_err_line", el_cnt, 3);
      frame_end();
      check("post_rst_frame_done", fd_cnt, 1);
      check("post_rst_err_frame", ef_cnt, 1);
      line(H);
      check("post_arm_count", wq.size(), H);
      check("post_arm_first", get_a(0), 9'h000);
      check("post_arm_last", get_a(H - 1), 9'h00F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
